// File: rtl/mtr_drv_pkg.sv
// Shared widths, defaults and helpers for the motor drive back end.
// Duty mapping turns a signed speed into an offset-binary PWM duty.
package mtr_drv_pkg;

    localparam int PWM_W = 11;
    localparam logic [PWM_W-1:0] DUTY_STOP = 11'h400;
    localparam logic [PWM_W-1:0] CNT_MAX = 11'h7FF;

    localparam int NONOVERLAP_DEF = 32;
    localparam int BLANK_DEF = 128;
    localparam int OVR_LIMIT_DEF = 4;

    typedef enum logic {
        NO_DEAD,
        NO_DRIVE
    } no_state_e;

    // Flip the sign bit and drop the LSB: -2048 -> 0, 0 -> 0x400.
    function automatic logic [PWM_W-1:0] spd_to_duty(
        input logic [11:0] spd
    );
        return {~spd[11], spd[10:1]};
    endfunction

endpackage

// File: rtl/pwm_nonoverlap.sv
// One H-bridge side: duty register, PWM compare and dead-time insertion.
// Gates follow the PWM signal only after a full quiet dead-time window.
module pwm_nonoverlap
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = NONOVERLAP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] duty_new,
    input  logic             load,
    output logic             pwm1,
    output logic             pwm2,
    output logic             hs_act
);

    localparam logic [7:0] DEAD_LD = 8'(NONOVERLAP);

    logic [PWM_W-1:0] duty;
    logic             sig;
    logic             sig_d;
    logic             sig_chg;

    no_state_e        state;
    no_state_e        state_nxt;
    logic [7:0]       dead;
    logic [7:0]       dead_nxt;
    logic             pwm1_nxt;
    logic             pwm2_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= DUTY_STOP;
        end else if (load) begin
            duty <= duty_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig   <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sig   <= (cnt < duty);
            sig_d <= sig;
        end
    end

    assign sig_chg = sig ^ sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NO_DEAD;
            dead  <= DEAD_LD;
            pwm1  <= 1'b0;
            pwm2  <= 1'b0;
        end else begin
            state <= state_nxt;
            dead  <= dead_nxt;
            pwm1  <= pwm1_nxt;
            pwm2  <= pwm2_nxt;
        end
    end

    // Any PWM edge, even mid dead time, restarts the quiet window.
    always_comb begin
        state_nxt = state;
        dead_nxt  = dead;
        pwm1_nxt  = 1'b0;
        pwm2_nxt  = 1'b0;
        if (sig_chg) begin
            state_nxt = NO_DEAD;
            dead_nxt  = DEAD_LD;
        end else begin
            unique case (state)
                NO_DEAD: begin
                    if (dead > 8'd1) begin
                        dead_nxt = dead - 8'd1;
                    end else begin
                        dead_nxt  = 8'd0;
                        state_nxt = NO_DRIVE;
                        pwm2_nxt  = sig;
                        pwm1_nxt  = ~sig;
                    end
                end
                NO_DRIVE: begin
                    pwm2_nxt = sig;
                    pwm1_nxt = ~sig;
                end
            endcase
        end
    end

    assign hs_act = pwm2;

endmodule

// File: rtl/mtr_drv.sv
// Motor drive top: shared PWM counter, two bridge sides and the
// over-current blanking, period accounting and sticky shutdown.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = NONOVERLAP_DEF,
    parameter int BLANK      = BLANK_DEF,
    parameter int OVR_LIMIT  = OVR_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        OVR_I_lft,
    input  logic        OVR_I_rght,
    output logic        PWM1_lft,
    output logic        PWM2_lft,
    output logic        PWM1_rght,
    output logic        PWM2_rght,
    output logic        OVR_I_shtdwn
);

    localparam logic [PWM_W-1:0] BLANK_C = PWM_W'(BLANK);
    localparam logic [3:0] LIMIT_C = 4'(OVR_LIMIT);

    logic [PWM_W-1:0] cnt;
    logic             wrap;
    logic [PWM_W-1:0] duty_lft;
    logic [PWM_W-1:0] duty_rght;

    logic p1_l, p2_l, hs_l;
    logic p1_r, p2_r, hs_r;

    logic [1:0] sync_l;
    logic [1:0] sync_r;
    logic       qual_l;
    logic       qual_r;
    logic       flt_now;
    logic       period_flt;
    logic [3:0] ovr_cnt;
    logic [3:0] ovr_inc;

    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end

    assign duty_lft  = spd_to_duty(lft_spd);
    assign duty_rght = spd_to_duty(rght_spd);

    pwm_nonoverlap #(
        .NONOVERLAP(NONOVERLAP)
    ) u_lft (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt     (cnt),
        .duty_new(duty_lft),
        .load    (wrap),
        .pwm1    (p1_l),
        .pwm2    (p2_l),
        .hs_act  (hs_l)
    );

    pwm_nonoverlap #(
        .NONOVERLAP(NONOVERLAP)
    ) u_rght (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt     (cnt),
        .duty_new(duty_rght),
        .load    (wrap),
        .pwm1    (p1_r),
        .pwm2    (p2_r),
        .hs_act  (hs_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_l <= 2'b00;
            sync_r <= 2'b00;
        end else begin
            sync_l <= {sync_l[0], OVR_I_lft};
            sync_r <= {sync_r[0], OVR_I_rght};
        end
    end

    // Ignore the switching spike at the start of each high-side pulse.
    assign qual_l  = sync_l[1] & hs_l & (cnt >= BLANK_C);
    assign qual_r  = sync_r[1] & hs_r & (cnt >= BLANK_C);
    assign flt_now = qual_l | qual_r;

    assign ovr_inc = (ovr_cnt == 4'hF) ? ovr_cnt : ovr_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_flt   <= 1'b0;
            ovr_cnt      <= 4'd0;
            OVR_I_shtdwn <= 1'b0;
        end else if (wrap) begin
            period_flt <= 1'b0;
            if (period_flt | flt_now) begin
                ovr_cnt <= ovr_inc;
                if (ovr_inc >= LIMIT_C) begin
                    OVR_I_shtdwn <= 1'b1;
                end
            end else begin
                ovr_cnt <= 4'd0;
            end
        end else if (flt_now) begin
            period_flt <= 1'b1;
        end
    end

    assign PWM1_lft  = p1_l & ~OVR_I_shtdwn;
    assign PWM2_lft  = p2_l & ~OVR_I_shtdwn;
    assign PWM1_rght = p1_r & ~OVR_I_shtdwn;
    assign PWM2_rght = p2_r & ~OVR_I_shtdwn;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: per-period gate high times from a
// vector table plus hand-written over-current and reset sequences.
module tb_mtr_drv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lft_spd = 12'h000;
    logic [11:0] rght_spd = 12'h000;
    logic        OVR_I_lft = 1'b0;
    logic        OVR_I_rght = 1'b0;
    logic        PWM1_lft;
    logic        PWM2_lft;
    logic        PWM1_rght;
    logic        PWM2_rght;
    logic        OVR_I_shtdwn;

    mtr_drv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lft_spd     (lft_spd),
        .rght_spd    (rght_spd),
        .OVR_I_lft   (OVR_I_lft),
        .OVR_I_rght  (OVR_I_rght),
        .PWM1_lft    (PWM1_lft),
        .PWM2_lft    (PWM2_lft),
        .PWM1_rght   (PWM1_rght),
        .PWM2_rght   (PWM2_rght),
        .OVR_I_shtdwn(OVR_I_shtdwn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] l;
        logic [11:0] r;
        int          p2l;
        int          p1l;
        int          p2r;
        int          p1r;
    } vec_t;

    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edges = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #2;
        edges++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
    endtask

    function automatic int any_gate();
        return int'(PWM1_lft | PWM2_lft | PWM1_rght | PWM2_rght);
    endfunction

    task automatic measure(output int p2l, output int p1l,
                           output int p2r, output int p1r,
                           output int ovl);
        p2l = 0; p1l = 0; p2r = 0; p1r = 0; ovl = 0;
        for (int i = 0; i < 2048; i++) begin
            adv();
            p2l += int'(PWM2_lft);
            p1l += int'(PWM1_lft);
            p2r += int'(PWM2_rght);
            p1r += int'(PWM1_rght);
            ovl += int'((PWM1_lft & PWM2_lft) | (PWM1_rght & PWM2_rght));
        end
    endtask

    initial begin
        int p2l, p1l, p2r, p1r, ovl, z;

        vecs[0] = '{12'h000, 12'h7FF, 992, 992, 2015, 0};
        vecs[1] = '{12'h800, 12'h200, 0, 2048, 1248, 736};
        vecs[2] = '{12'hE00, 12'h001, 736, 1248, 992, 992};
        vecs[3] = '{12'h7D0, 12'h820, 1992, 0, 0, 2000};

        #3;
        chk("rst_gates", any_gate(), 0);
        chk("rst_shtdwn", int'(OVR_I_shtdwn), 0);

        for (int v = 0; v < 4; v++) begin
            lft_spd  = vecs[v].l;
            rght_spd = vecs[v].r;
            do_reset();
            z = 0;
            repeat (33) begin
                adv();
                z += any_gate();
            end
            chk($sformatf("v%0d_dead_after_rst", v), z, 0);
            adv();
            chk($sformatf("v%0d_first_p2l", v), int'(PWM2_lft), 1);
            chk($sformatf("v%0d_first_p2r", v), int'(PWM2_rght), 1);
            repeat (4096 - 34) adv();
            measure(p2l, p1l, p2r, p1r, ovl);
            chk($sformatf("v%0d_p2l", v), p2l, vecs[v].p2l);
            chk($sformatf("v%0d_p1l", v), p1l, vecs[v].p1l);
            chk($sformatf("v%0d_p2r", v), p2r, vecs[v].p2r);
            chk($sformatf("v%0d_p1r", v), p1r, vecs[v].p1r);
            chk($sformatf("v%0d_overlap", v), ovl, 0);
        end

        // Speed change mid-period takes effect only after the wrap.
        lft_spd  = 12'h000;
        rght_spd = 12'h000;
        do_reset();
        z = 0;
        for (int i = 1; i <= 2048; i++) begin
            adv();
            if (i == 256) lft_spd = 12'h200;
            z += int'(PWM2_lft);
        end
        chk("mid_chg_old_period", z, 992);
        z = 0;
        repeat (2048) begin
            adv();
            z += int'(PWM2_lft);
        end
        chk("mid_chg_new_period", z, 1248);

        // Held over-current: shutdown at the end of the 4th period.
        lft_spd   = 12'h000;
        OVR_I_lft = 1'b1;
        do_reset();
        repeat (8191) adv();
        chk("held_shtdwn_pre", int'(OVR_I_shtdwn), 0);
        adv();
        chk("held_shtdwn_set", int'(OVR_I_shtdwn), 1);
        chk("held_gates_off", any_gate(), 0);
        OVR_I_lft = 1'b0;
        z = 0;
        repeat (2048) begin
            adv();
            z += any_gate();
        end
        chk("shtdwn_gates_held", z, 0);
        chk("shtdwn_sticky", int'(OVR_I_shtdwn), 1);
        repeat (700) adv();
        rst_n = 1'b0;
        #1;
        chk("async_rst_shtdwn", int'(OVR_I_shtdwn), 0);
        chk("async_rst_gates", any_gate(), 0);

        // Pulses inside the blanking window are never counted.
        OVR_I_lft = 1'b0;
        do_reset();
        repeat (5 * 2048) begin
            adv();
            OVR_I_lft = ((edges % 2048) >= 40) && ((edges % 2048) <= 90);
        end
        chk("blank_no_shtdwn", int'(OVR_I_shtdwn), 0);
        OVR_I_lft = 1'b1;
        repeat (4 * 2048) adv();
        chk("blank_then_held", int'(OVR_I_shtdwn), 1);
        OVR_I_lft = 1'b0;

        // Clean period between fault runs clears the count.
        OVR_I_rght = 1'b1;
        do_reset();
        for (int p = 1; p <= 7; p++) begin
            OVR_I_rght = (p != 4);
            repeat (2048) adv();
        end
        chk("rght_3_clean_3", int'(OVR_I_shtdwn), 0);
        OVR_I_rght = 1'b1;
        repeat (2047) adv();
        chk("rght_4th_pre", int'(OVR_I_shtdwn), 0);
        adv();
        chk("rght_4th_set", int'(OVR_I_shtdwn), 1);
        OVR_I_rght = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mtr_drv.md
# mtr_drv

Motor drive back end that consumes the signed wheel-speed commands produced by the balance math block and turns them into complementary H-bridge gate signals for the left and right motors. Each speed is mapped to an 11-bit duty cycle, compared against a free-running PWM counter, and given non-overlap dead time. Over-current flags from the bridge are sampled in a blanking window, and repeated faults latch a shutdown that forces every gate low.

## Interface
- NONOVERLAP, 32: dead-time cycles with both gates of a bridge low after any PWM edge (2..255).
- BLANK, 128: PWM counter value below which over-current samples are ignored.
- OVR_LIMIT, 4: consecutive faulted PWM periods that trigger shutdown (1..15).
- clk  input  1  system clock; one clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- lft_spd  input  12  signed left speed command, -2048..2047.
- rght_spd  input  12  signed right speed command.
- OVR_I_lft  input  1  left bridge over-current, active-high, asynchronous.
- OVR_I_rght  input  1  right bridge over-current, active-high, asynchronous.
- PWM1_lft, PWM2_lft  output  1 each  left low-side/high-side gate (PWM2 drives forward).
- PWM1_rght, PWM2_rght  output  1 each  right gates.
- OVR_I_shtdwn  output  1  latched over-current shutdown.

## Operation
- Duty mapping: duty = {~spd[11], spd[10:1]}, 11 bits unsigned. 12'h800 maps to 0, 12'h000 to 0x400 (stop), 12'h7FF to 0x7FF.
- One shared 11-bit counter cnt runs 0..0x7FF and wraps to 0 every 2048 cycles.
- Duty registers load from the mapped inputs only on the edge where cnt wraps 0x7FF to 0. Mid-period input changes are ignored until the next wrap. Reset value is 0x400.
- PWM_sig per side is a register equal to (cnt < duty). duty = 0 gives a constant 0.
- Non-overlap per side:
  - When PWM_sig changes, both gates go low on the next edge and the dead counter loads NONOVERLAP.
  - When the dead counter expires, PWM2 = PWM_sig and PWM1 = ~PWM_sig.
  - A PWM_sig change during dead time restarts the dead counter.
- Over-current path:
  - Each OVR_I input passes through a 2-flop synchronizer.
  - A sample qualifies when the synchronized OVR_I = 1, that side's PWM2 = 1, and cnt >= BLANK.
  - A period fault flag is set on any qualified sample from either side.
- Period accounting, evaluated on the wrap edge:
  - If the period fault flag is set, ovr_cnt increments; otherwise ovr_cnt clears to 0.
  - The period fault flag then clears.
  - When ovr_cnt reaches OVR_LIMIT, OVR_I_shtdwn sets.
- OVR_I_shtdwn is sticky until rst_n. While it is set, all four gates are held 0. cnt keeps running.

## Timing
- Reset values:
  - All gate outputs 0, OVR_I_shtdwn 0.
  - cnt 0, ovr_cnt 0, PWM_sig 0.
  - Dead counters loaded with NONOVERLAP, so both gates stay low for at least NONOVERLAP cycles after reset.
- Speed-to-gate latency: the new duty takes effect at the first wrap after the input change. The first gate edge follows 1 + NONOVERLAP cycles after that PWM_sig edge.
- OVR_I latency: 2 synchronizer cycles before the qualification check.
- OVR_I_shtdwn asserts on the wrap edge that ends the OVR_LIMIT-th consecutive faulted period. Gates are 0 from the following cycle.
- Reset asserted mid-period returns every register to its reset value immediately (asynchronous).
- A PWM_sig pulse shorter than NONOVERLAP suppresses that gate entirely; it never produces a glitch.

## Structure
- Package mtr_drv_pkg holds:
  - PWM_W = 11 and DUTY_STOP = 11'h400.
  - A spd_to_duty function.
  - Default values for NONOVERLAP, BLANK and OVR_LIMIT.
- Sub-module pwm_nonoverlap, instantiated once per side. It takes cnt, duty and a load strobe, and outputs PWM1, PWM2 and a high-side-active indication.
- Counter, synchronizers and fault accounting live in the top module.

## Test plan
All scenarios use default parameters.
- Reset, lft_spd = 0: both left gates 0 for 32 cycles. In steady state per 2048-cycle period, PWM2_lft is high 992 cycles and PWM1_lft high 992 cycles, with 32-cycle gaps at each edge and never both high.
- rght_spd = 12'h7FF: PWM1_rght stays 0, because the 1-cycle low pulse is shorter than the dead time. PWM2_rght is high 2015 of every 2048 cycles.
- lft_spd = 12'h800: PWM2_lft never asserts; PWM1_lft is constantly high after the first dead time.
- lft_spd changes 0 → 12'h200 at cnt = 0x100: the current period keeps duty 0x400. The next period uses duty 0x500, so PWM2_lft high time becomes 1248 cycles.
- OVR_I_lft pulsed only while cnt < 100: no fault is counted. OVR_I_lft held high with lft_spd = 0: OVR_I_shtdwn rises at the end of the 4th period and all gates go 0, staying there until rst_n.
- OVR_I_rght faulted in 3 consecutive periods, then one clean period, then 3 more faulted: ovr_cnt clears after the clean period and OVR_I_shtdwn stays 0.
